// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory block: FSM state type, sign_mask
// encodings, access-size decode, latched request record and default
// address-map constants.
// -----------------------------------------------------------------------------
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_BUFFER,
    ST_READ,
    ST_WRITE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // sign_mask[2:0] size encodings and the sign-extend flag position
  localparam logic [2:0] SM_BYTE     = 3'b001;
  localparam logic [2:0] SM_HALF     = 3'b011;
  localparam logic [2:0] SM_WORD     = 3'b111;
  localparam int         SM_SIGN_BIT = 3;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

  // Request captured in IDLE and held for the whole stall sequence
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
    logic        is_write;
  } req_t;

  // Unknown size codes fall back to a full-word access
  function automatic size_e decode_size(input logic [2:0] code);
    case (code)
      SM_BYTE: return SZ_BYTE;
      SM_HALF: return SZ_HALF;
      SM_WORD: return SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Core-side load/store bus of the data memory.
//   addr        byte address of the access
//   write_data  store data, right-justified
//   memwrite    store request (pulse)
//   memread     load request (pulse)
//   sign_mask   [2:0] size, [3] sign-extend loads
//   read_data   registered load result
//   clk_stall   high while an access is in progress
// -----------------------------------------------------------------------------
interface data_mem_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, clk_stall
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, clk_stall
  );
endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane logic for the data memory.
//   word_i   buffered 32-bit memory word
//   wdata_i  right-justified store data
//   lane_i   addr[1:0] of the access
//   size_i   decoded access size
//   sign_i   1 = sign-extend loads, 0 = zero-extend
//   load_o   selected lanes right-justified and extended
//   store_o  word_i with the selected lanes replaced by wdata_i
// -----------------------------------------------------------------------------
module dmem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave it unassigned (no latches).
  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase

    // Half accesses ignore addr[0]
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    store_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd1:    store_o[15:8]  = wdata_i[7:0];
          2'd2:    store_o[23:16] = wdata_i[7:0];
          2'd3:    store_o[31:24] = wdata_i[7:0];
          default: store_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) store_o[31:16] = wdata_i[15:0];
        else           store_o[15:0]  = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Stalling data memory with a memory-mapped LED register. Each access takes
// two stall cycles: the word is fetched into a buffer, then either aligned
// into read_data (load) or merged and written back (store).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_if slave (addr, write_data, memwrite, memread, sign_mask,
//          read_data, clk_stall)
//   led    registered LED output
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus,
  output logic [7:0] led
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        stall_q, stall_d;
  logic [31:0] read_data_q, read_data_d;
  logic [7:0]  led_q, led_d;

  logic        mem_we;
  logic        buf_en;
  logic [31:0] offset;
  logic        in_range;
  logic        hit_led;
  logic [IDX_W-1:0] idx;
  size_e       size;
  logic [31:0] buf_q;
  logic [31:0] load_word;
  logic [31:0] store_word;
  logic [31:0] mem_q [MEM_WORDS];

  // Address decode works on the latched request, stable for the whole access.
  // A base above addr wraps offset to a large value, so the first term only
  // matters when the window reaches the top of the address space.
  assign offset   = req_q.addr - MEM_BASE;
  assign in_range = (req_q.addr >= MEM_BASE) && (offset < MEM_BYTES);
  assign idx      = offset[IDX_W+1:2];
  assign hit_led  = (req_q.addr == LED_ADDR);
  assign size     = decode_size(req_q.sign_mask[2:0]);

  dmem_lane_align u_align (
    .word_i  (buf_q),
    .wdata_i (req_q.wdata),
    .lane_i  (req_q.addr[1:0]),
    .size_i  (size),
    .sign_i  (req_q.sign_mask[SM_SIGN_BIT]),
    .load_o  (load_word),
    .store_o (store_word)
  );

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (bus.memread || bus.memwrite) state_d = ST_READ_BUFFER;
      ST_READ_BUFFER: state_d = req_q.is_write ? ST_WRITE : ST_READ;
      ST_READ:        state_d = ST_IDLE;
      ST_WRITE:       state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    req_d       = req_q;
    stall_d     = stall_q;
    read_data_d = read_data_q;
    led_d       = led_q;
    mem_we      = 1'b0;
    buf_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write wins when both requests are high; requests in other states
        // are simply not looked at.
        if (bus.memread || bus.memwrite) begin
          req_d = '{addr:      bus.addr,
                    wdata:     bus.write_data,
                    sign_mask: bus.sign_mask,
                    is_write:  bus.memwrite};
          stall_d = 1'b1;
        end
      end
      ST_READ_BUFFER: buf_en = 1'b1;
      ST_READ: begin
        stall_d = 1'b0;
        if (hit_led)       read_data_d = {24'h0, led_q};
        else if (in_range) read_data_d = load_word;
        else               read_data_d = 32'h0;
      end
      ST_WRITE: begin
        stall_d = 1'b0;
        if (hit_led)       led_d  = req_q.wdata[7:0];
        else if (in_range) mem_we = 1'b1;
      end
      default: stall_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      stall_q     <= 1'b0;
      read_data_q <= 32'h0;
      led_q       <= 8'h0;
    end else begin
      req_q       <= req_d;
      stall_q     <= stall_d;
      read_data_q <= read_data_d;
      led_q       <= led_d;
    end
  end

  // ------------------------------------------------------------------- memory
  // NOTE: the array and its read buffer carry no reset so they map onto a
  // block RAM; an abort by reset is safe because state_q drops to IDLE at
  // once, which removes mem_we before the next edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= store_word;
    if (buf_en) buf_q      <= mem_q[idx];
  end

  assign bus.read_data = read_data_q;
  assign bus.clk_stall = stall_q;
  assign led           = led_q;

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Self-checking bench for data_mem: directed vectors plus randomized
// loads/stores compared against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_data_mem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] TOP   = 32'h0000_2000;
  localparam logic [31:0] LED_A = 32'h0000_2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led;

  data_mem_if bus ();

  data_mem #(
    .MEM_BASE  (BASE),
    .MEM_WORDS (1024),
    .LED_ADDR  (LED_A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] mdl_mem [int];
  logic [7:0]  mdl_led;
  logic [31:0] mdl_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Byte lanes covered by an access and the shift placing data into them
  function automatic void lanes_of(input logic [31:0] a, input logic [3:0] m,
                                   output logic [31:0] lanes, output int sh);
    if (m[2:0] == 3'b001) begin
      sh    = 8 * int'(a[1:0]);
      lanes = 32'h0000_00ff << sh;
    end else if (m[2:0] == 3'b011) begin
      sh    = a[1] ? 16 : 0;
      lanes = 32'h0000_ffff << sh;
    end else begin
      sh    = 0;
      lanes = 32'hffff_ffff;
    end
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [3:0] m);
    logic [31:0] lanes, v;
    int sh;
    lanes_of(a, m, lanes, sh);
    v = (w & lanes) >> sh;
    if (m[3] && m[2:0] == 3'b001 && v[7])  v = v | 32'hffff_ff00;
    if (m[3] && m[2:0] == 3'b011 && v[15]) v = v | 32'hffff_0000;
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [31:0] a, input logic [3:0] m);
    logic [31:0] lanes;
    int sh;
    lanes_of(a, m, lanes, sh);
    return (old & ~lanes) | ((d << sh) & lanes);
  endfunction

  task automatic mdl_apply(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
    if (wr) begin
      if (a == LED_A)  mdl_led = d[7:0];
      else if (in_mem(a)) mdl_mem[widx(a)] = mdl_store(mdl_mem[widx(a)], d, a, m);
    end else if (rd) begin
      if (a == LED_A)     mdl_rd = {24'h0, mdl_led};
      else if (in_mem(a)) mdl_rd = mdl_load(mdl_mem[widx(a)], a, m);
      else                mdl_rd = 32'h0;
    end
  endtask

  // One request pulse, then follow the stall. Called and returns at a negedge.
  // poke drives a stray store while busy; it must be ignored.
  task automatic access(input string tag, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit poke);
    int cnt;
    logic [31:0] rd_before;
    rd_before      = bus.read_data;
    bus.addr       = a;
    bus.write_data = d;
    bus.sign_mask  = m;
    bus.memwrite   = wr;
    bus.memread    = rd;
    @(negedge clk);
    bus.memwrite   = 1'b0;
    bus.memread    = 1'b0;
    bus.addr       = $urandom;
    bus.write_data = $urandom;
    bus.sign_mask  = 4'($urandom);
    cnt = 0;
    while (bus.clk_stall === 1'b1 && cnt < 10) begin
      if (wr && rd) check({tag, " dual hold"}, bus.read_data, rd_before);
      if (poke && cnt == 0) begin
        bus.addr       = 32'h0000_1ffc;
        bus.write_data = $urandom;
        bus.sign_mask  = 4'b0111;
        bus.memwrite   = 1'b1;
      end else begin
        bus.memwrite   = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    bus.memwrite = 1'b0;
    mdl_apply(wr, rd, a, d, m);
    check({tag, " stall cycles"}, 32'(cnt), 32'd2);
    check({tag, " read_data"}, bus.read_data, mdl_rd);
    check({tag, " led"}, {24'h0, led}, {24'h0, mdl_led});
  endtask

  logic [3:0] mask_tbl [8];
  logic [31:0] oor_tbl [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] prior, a, d;
    logic [3:0]  m;
    int r;
    bit wr, rd;

    mask_tbl = '{4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0111, 4'b1111, 4'b0000, 4'b0101};
    oor_tbl  = '{32'h0000_0ffc, 32'h0000_3000, 32'h0000_0000, 32'h0000_2004};

    bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
    bus.memwrite = 1'b0; bus.memread = 1'b0;
    mdl_led = 8'h0; mdl_rd = 32'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset clk_stall", {31'h0, bus.clk_stall}, 32'h0);
    check("reset read_data", bus.read_data, 32'h0);
    check("reset led", {24'h0, led}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    access("w 1100", 1, 0, 32'h1100, 32'hff03ab21, 4'b0111, 0);
    access("rw 1100", 0, 1, 32'h1100, 32'h0, 4'b0111, 0);
    check("lit rw 1100", bus.read_data, 32'hff03ab21);
    access("rb 1103 s", 0, 1, 32'h1103, 32'h0, 4'b1001, 0);
    check("lit rb 1103 s", bus.read_data, 32'hffffffff);
    access("rb 1100 u", 0, 1, 32'h1100, 32'h0, 4'b0001, 0);
    check("lit rb 1100 u", bus.read_data, 32'h00000021);
    access("rh 1102 s", 0, 1, 32'h1102, 32'h0, 4'b1011, 0);
    check("lit rh 1102 s", bus.read_data, 32'hffffff03);
    access("wb 1101", 1, 0, 32'h1101, 32'h00000055, 4'b0001, 0);
    access("rw 1100 merged", 0, 1, 32'h1100, 32'h0, 4'b0111, 0);
    check("lit rw merged", bus.read_data, 32'hff035521);
    access("w 1000", 1, 0, 32'h1000, 32'hdeadbeef, 4'b0111, 0);
    access("w led", 1, 0, LED_A, 32'h000000a5, 4'b0111, 0);
    check("lit led", {24'h0, led}, 32'h000000a5);
    access("rw 1000 after led", 0, 1, 32'h1000, 32'h0, 4'b0111, 0);
    check("lit 1000 unchanged", bus.read_data, 32'hdeadbeef);
    access("r led", 0, 1, LED_A, 32'h0, 4'b1001, 0);
    check("lit r led", bus.read_data, 32'h000000a5);
    access("dual 1104", 1, 1, 32'h1104, 32'h12345678, 4'b0111, 0);
    access("rw 1104", 0, 1, 32'h1104, 32'h0, 4'b0111, 0);
    check("lit rw 1104", bus.read_data, 32'h12345678);
    access("w oor 3000", 1, 0, 32'h3000, 32'hcafef00d, 4'b0111, 0);
    access("r oor 3000", 0, 1, 32'h3000, 32'h0, 4'b0111, 0);
    check("lit r oor", bus.read_data, 32'h0);

    // Prefill a region plus the last in-range word so random loads are defined
    for (int i = 0; i < 32; i++)
      access("fill", 1, 0, BASE + 32'(i * 4), $urandom, 4'b0111, 0);
    access("fill top", 1, 0, 32'h1ffc, $urandom, 4'b0111, 0);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      else if (r == 7) a = LED_A;
      else if (r == 8) a = oor_tbl[$urandom_range(0, 3)];
      else             a = 32'h1ffc + 32'($urandom_range(0, 3));
      m = mask_tbl[$urandom_range(0, 7)];
      d = $urandom;
      r = $urandom_range(0, 9);
      wr = (r < 4) || (r == 9);
      rd = (r >= 4);
      access("rand", wr, rd, a, d, m, $urandom_range(0, 3) == 0);
    end
    access("rw 1ffc after pokes", 0, 1, 32'h1ffc, 32'h0, 4'b0111, 0);

    // Reset while in WRITE must abort the store
    access("w led pre-reset", 1, 0, LED_A, 32'h0000005a, 4'b0111, 0);
    prior          = mdl_mem[widx(32'h1100)];
    bus.addr       = 32'h1100;
    bus.write_data = ~prior;
    bus.sign_mask  = 4'b0111;
    bus.memwrite   = 1'b1;
    @(negedge clk);
    bus.memwrite   = 1'b0;
    check("abort stall in buffer", {31'h0, bus.clk_stall}, 32'h1);
    @(negedge clk);
    check("abort stall in write", {31'h0, bus.clk_stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort clk_stall", {31'h0, bus.clk_stall}, 32'h0);
    check("abort read_data", bus.read_data, 32'h0);
    check("abort led", {24'h0, led}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_led = 8'h0;
    mdl_rd  = 32'h0;
    access("rw 1100 after abort", 0, 1, 32'h1100, 32'h0, 4'b0111, 0);
    check("lit 1100 kept", bus.read_data, prior);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter MEM_BASE, default 32'h0000_1000: byte address of memory word 0.
REQ-002 Parameter MEM_WORDS, default 1024: memory depth in 32-bit words (4 KiB).
REQ-003 Parameter LED_ADDR, default 32'h0000_2000: byte address of the LED output register.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 addr  input  32  byte address of the access.
REQ-008 write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 memwrite  input  1  store request; a single-cycle pulse is sufficient.
REQ-010 memread  input  1  load request; a single-cycle pulse is sufficient.
REQ-011 sign_mask  input  4  size and sign: [2:0]=3'b001 byte, 3'b011 half, 3'b111 word; [3]=1 sign-extend loads, [3]=0 zero-extend.
REQ-012 read_data  output  32  load result, registered, held until the next load completes.
REQ-013 led  output  8  registered LED register.
REQ-014 clk_stall  output  1  registered; high while an access is in progress, so the core freezes.

Function
REQ-015 FSM states: IDLE, READ_BUFFER, READ, WRITE.
REQ-016 IDLE: on a rising edge with memread or memwrite high, latch addr, write_data, sign_mask and request type, set clk_stall=1, and go to READ_BUFFER.
REQ-017 READ_BUFFER: fetch the addressed word into a buffer. Go to WRITE if the request was a write, else READ. clk_stall stays 1.
REQ-018 READ: drive the aligned and extended result into read_data, clear clk_stall, and go to IDLE.
REQ-019 WRITE: merge the selected byte lanes of the latched data into the buffered word, write it back, clear clk_stall, and go to IDLE.
REQ-020 Latency: clk_stall is high for exactly 2 cycles per access. read_data is valid from the edge that clears clk_stall.
REQ-021 Word index = (addr - MEM_BASE)[11:2]. In range means MEM_BASE <= addr < MEM_BASE + 4*MEM_WORDS.
REQ-022 Lane selection:
- Byte access uses lane addr[1:0].
- Half access uses addr[1] (0 gives [15:0], 1 gives [31:16]); addr[0] is ignored.
- Word access ignores addr[1:0].
REQ-023 Loads: right-justify the selected lanes, then extend from bit 7 (byte) or bit 15 (half) per sign_mask[3].
REQ-024 Stores modify only the selected lanes; the other lanes keep their old content.
REQ-025 A store to LED_ADDR sets led to write_data[7:0]; memory is unchanged. A load from LED_ADDR returns {24'b0, led}.
REQ-026 Other out-of-range addresses: loads return 32'h0 and stores are ignored. Both still take the full stall sequence.
REQ-027 memread and memwrite high together: the write takes priority, the read is dropped, and read_data keeps its old value.
REQ-028 Requests that arrive while not in IDLE are ignored; they are not queued.
REQ-029 sign_mask[2:0] values other than 001, 011 or 111 are treated as word access.

Reset
REQ-030 While rst_n is low, regardless of clk:
- state = IDLE
- clk_stall = 0
- read_data = 32'h0
- led = 8'h0
- latched request cleared
REQ-031 Memory contents are not reset.
REQ-032 Reset during READ_BUFFER or WRITE aborts the access with no memory or LED update.

Structure
REQ-033 A shared package holds:
- the FSM state typedef
- the sign_mask encodings (BYTE, HALF, WORD, SIGN bit)
- MEM_BASE and LED_ADDR defaults
REQ-034 A combinational sub-module, dmem_lane_align, performs load extract/extend and store lane merge. The memory array is inferable as block RAM with one read and one write port.

Verification
REQ-035 Reset release, then write addr=0x1100, data=0xff03ab21, mask=0111 (1-cycle pulse):
- clk_stall is 1 for 2 cycles
- a later word read of 0x1100 returns read_data=0xff03ab21.
REQ-036 With 0xff03ab21 stored at 0x1100:
- byte read 0x1103, mask=1001 -> 0xffffffff
- byte read 0x1100, mask=0001 -> 0x00000021
- half read 0x1102, mask=1011 -> 0xffffff03
REQ-037 Byte write 0x55 to 0x1101 over 0xff03ab21, then word read -> 0xff035521.
REQ-038 Word write 0x000000a5 to 0x2000 -> led=8'b10100101; memory word at 0x1000 unchanged.
REQ-039 Simultaneous memread and memwrite to 0x1104 with data 0x12345678 -> a subsequent read returns 0x12345678, and read_data is unchanged during the dual request.
REQ-040 rst_n asserted low during WRITE -> clk_stall drops immediately and the target word keeps its prior value.
